// File: rtl/alu_cc_pkg.sv
// rtl/alu_cc_pkg.sv - shared opcode, state and width definitions for the ALU condition-code stage
package alu_cc_pkg;

    localparam int BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_ADC  = 3'b100,
        OP_SBC  = 3'b101,
        OP_CMP  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC1 = 2'b01,
        S_EXEC2 = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/AddSub8Bit.sv
// rtl/AddSub8Bit.sv - combinational adder/subtractor; carry is carry-out on add, no-borrow on subtract
module AddSub8Bit #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            sub,
    output logic [BITS-1:0] result,
    output logic            carry
);

    logic [BITS:0] total;

    // Subtract as a + ~b + 1 so the carry-out reads directly as "no borrow".
    assign total  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{BITS{1'b0}}, sub};
    assign result = total[BITS-1:0];
    assign carry  = total[BITS];

endmodule

// File: rtl/alu_cc_stage.sv
// rtl/alu_cc_stage.sv - multi-cycle accumulator ALU stage with registered condition codes
module alu_cc_stage
    import alu_cc_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [BITS-1:0] operand,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] acc,
    output logic            ccc,
    output logic            ccn,
    output logic            ccz,
    output logic            ccv
);

    state_e          state, state_nxt;
    op_e             op_q;
    logic [BITS-1:0] operand_q;
    logic [BITS-1:0] pass1_q;
    logic            carry1_q;

    logic [BITS-1:0] add_a, add_b, add_res;
    logic            add_sub, add_carry;
    logic            sub_op, two_pass, finish, carry_fin, ovf;
    logic            accept;

    assign in_ready  = (state == S_IDLE) && rst_n;
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign sub_op    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
    assign two_pass  = (op_q == OP_ADC) || (op_q == OP_SBC);
    assign finish    = ((state == S_EXEC1) && !two_pass) || (state == S_EXEC2);

    // Second pass folds the old carry into the pass-1 result; ccc is still the old value here.
    always_comb begin
        add_a   = acc;
        add_b   = operand_q;
        add_sub = sub_op;
        if (state == S_EXEC2) begin
            add_a   = pass1_q;
            add_b   = {{(BITS-1){1'b0}}, ((op_q == OP_SBC) ? !ccc : ccc)};
            add_sub = (op_q == OP_SBC);
        end
    end

    AddSub8Bit #(.BITS(BITS)) u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .result (add_res),
        .carry  (add_carry)
    );

    always_comb begin
        carry_fin = add_carry;
        if (state == S_EXEC2) begin
            carry_fin = (op_q == OP_ADC) ? (carry1_q | add_carry) : (carry1_q & add_carry);
        end
        if (sub_op) begin
            ovf = (acc[BITS-1] != operand_q[BITS-1]) && (add_res[BITS-1] != acc[BITS-1]);
        end else begin
            ovf = (acc[BITS-1] == operand_q[BITS-1]) && (add_res[BITS-1] != acc[BITS-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_EXEC1;
            S_EXEC1: state_nxt = two_pass ? S_EXEC2 : S_DONE;
            S_EXEC2: state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            operand_q <= '0;
            pass1_q   <= '0;
            carry1_q  <= 1'b0;
            acc       <= '0;
            ccc       <= 1'b0;
            ccn       <= 1'b0;
            ccz       <= 1'b1;
            ccv       <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= op_e'(op);
                operand_q <= operand;
            end
            if ((state == S_EXEC1) && two_pass) begin
                pass1_q  <= add_res;
                carry1_q <= add_carry;
            end
            if (finish) begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
                        if (op_q != OP_CMP) acc <= add_res;
                        ccc <= carry_fin;
                        ccn <= sub_op & ~carry_fin;
                        ccz <= (add_res == '0);
                        ccv <= ovf;
                    end
                    OP_LOAD: begin
                        acc <= operand_q;
                        ccz <= (operand_q == '0);
                        ccn <= 1'b0;
                        ccv <= 1'b0;
                    end
                    OP_CLR: begin
                        acc <= '0;
                        ccz <= 1'b1;
                        ccn <= 1'b0;
                        ccv <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_cc_stage.sv
// tb/tb_alu_cc_stage.sv - directed and randomized checks of alu_cc_stage against an arithmetic model
module tb_alu_cc_stage;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] operand = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] acc;
    logic         ccc, ccn, ccz, ccv;

    int checks = 0;
    int errors = 0;

    int m_acc = 0;
    int m_c = 0, m_n = 0, m_z = 1, m_v = 0;

    always #5 clk = ~clk;

    alu_cc_stage #(.BITS(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .ccc       (ccc),
        .ccn       (ccn),
        .ccz       (ccz),
        .ccv       (ccv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_n = 0; m_z = 1; m_v = 0;
    endtask

    // Whole-operation arithmetic on integers: carry-in/borrow-in folded into one sum.
    task automatic model(input int o, input int b);
        int a, cin, s, r, sv;
        a = m_acc;
        case (o)
            1: begin m_acc = b; m_z = (b == 0); m_n = 0; m_v = 0; end
            7: begin m_acc = 0; m_z = 1; m_n = 0; m_v = 0; end
            2, 4: begin
                cin = (o == 4) ? m_c : 0;
                s  = a + b + cin;
                sv = sgn(a) + sgn(b) + cin;
                r  = s % MOD;
                m_c = (s >= MOD); m_n = 0; m_z = (r == 0);
                m_v = (sv > MOD / 2 - 1) || (sv < -MOD / 2);
                m_acc = r;
            end
            3, 5, 6: begin
                cin = (o == 5) ? (1 - m_c) : 0;
                s  = a - b - cin;
                sv = sgn(a) - sgn(b) - cin;
                r  = (s + 2 * MOD) % MOD;
                m_c = (s >= 0); m_n = (s < 0); m_z = (r == 0);
                m_v = (sv > MOD / 2 - 1) || (sv < -MOD / 2);
                if (o != 6) m_acc = r;
            end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, acc, m_acc);
        chk({tag, "_ccc"}, ccc, m_c);
        chk({tag, "_ccn"}, ccn, m_n);
        chk({tag, "_ccz"}, ccz, m_z);
        chk({tag, "_ccv"}, ccv, m_v);
    endtask

    task automatic do_op(input int o, input int b, input int hold);
        int n;
        logic [W-1:0] acc_h;
        logic [3:0]   fl_h;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", in_ready, 1);
        in_valid = 1'b1; op = o[2:0]; operand = b[W-1:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        model(o, b);
        chk("latency", n, (o == 4 || o == 5) ? 2 : 1);
        chk_state("res");
        chk("busy_ready", in_ready, 0);
        acc_h = acc; fl_h = {ccc, ccn, ccz, ccv};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op = 3'($urandom); operand = W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_acc", acc, acc_h);
            chk("hold_flags", {ccc, ccn, ccz, ccv}, fl_h);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle", in_ready, 1);
        chk("back_valid", out_valid, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk_state("rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);

        do_op(1, 8'h01, 0);
        do_op(2, 8'h7F, 0);
        chk("add_ovf_acc", acc, 8'h80);
        chk("add_ovf_v", ccv, 1);

        do_op(1, 8'h05, 0);
        do_op(3, 8'h07, 0);
        chk("sub_acc", acc, 8'hFE);
        chk("sub_n", ccn, 1);

        do_op(1, 8'hFF, 0);
        do_op(2, 8'h01, 0);
        do_op(4, 8'h00, 0);
        chk("adc1_acc", acc, 8'h01);
        chk("adc1_c", ccc, 0);

        do_op(2, 8'hFF, 0);
        do_op(1, 8'hFF, 0);
        do_op(4, 8'h00, 0);
        chk("adc2_acc", acc, 8'h00);
        chk("adc2_cz", {ccc, ccz}, 2'b11);

        do_op(1, 8'h42, 0);
        do_op(6, 8'h42, 0);
        chk("cmp_acc", acc, 8'h42);
        chk("cmp_czn", {ccc, ccz, ccn}, 3'b110);

        do_op(2, 8'h13, 5);
        do_op(7, 0, 1);
        do_op(0, 8'h55, 0);

        for (int k = 0; k < 60; k++) begin
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 2)));
        end

        // Abort an SBC in its second pass: nothing may be written back.
        do_op(1, 8'h30, 0);
        in_valid = 1'b1; op = 3'd5; operand = 8'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state("abort");
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", in_ready, 1);
        do_op(2, 8'h03, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
